ram_stream_reader: RTL
======================

// Module: ram_stream_reader
// PURPOSE
//  Port master for one port of the dual-port RAM. Reads nwords words starting at base_addr and
//  emits them in order on a valid/ready stream. Hides the RAM's 1-cycle registered-read latency
//  with a 2-entry output buffer. Feeds the vector datapath from RAM-resident operand vectors.
// PARAMETERS
//  RAMSIZE    1924             words in the attached RAM; addresses wrap modulo RAMSIZE
//  DATAWIDTH  32               RAM word / stream data width
//  AW         $clog2(RAMSIZE)  address width (derived, not overridden)
// PORTS
//  clock        in   1            single clock, shared with the attached RAM port
//  reset_n      in   1            asynchronous active-low reset
//  start        in   1            1-cycle request; sampled only in IDLE
//  base_addr    in   AW           first word address
//  nwords       in   AW+1         number of words to read
//  busy         out  1            high from accepted start until done
//  done         out  1            1-cycle pulse after last word handshake (or empty job)
//  err          out  1            1-cycle pulse: start rejected, base_addr >= RAMSIZE
//  ram_addr     out  AW           RAM addr, registered
//  ram_wdata    out  DATAWIDTH    RAM Wdata, constant 0
//  ram_wenable  out  1            RAM Wenable (see CONFIGURATION)
//  ram_rdata    in   DATAWIDTH    RAM Rdata, valid the cycle after the address is sampled
//  out_data     out  DATAWIDTH    stream data
//  out_valid    out  1            stream valid
//  out_ready    in   1            stream ready; a transfer occurs when out_valid && out_ready
// BEHAVIOUR
//  - Reset: all outputs 0; FSM->IDLE; buffer, in-flight flag, and counters cleared. Applies mid-job.
//    Any in-flight read is discarded.
//  - FSM: IDLE -start&&base ok&&nwords!=0-> RUN; RUN -all reads issued-> DRAIN;
//    DRAIN -buffer empty, no read in flight-> IDLE, with done=1 for one cycle.
//  - start with nwords==0 and base ok: no RAM access; done pulses next cycle; busy stays 0.
//  - start with base_addr>=RAMSIZE: ignored; err pulses next cycle. start is ignored when not IDLE.
//  - nwords>RAMSIZE: clamped to RAMSIZE.
//  - Issue rule: a read issues in a cycle only if
//    (buffer count + in-flight - pop this cycle) < 2.
//    Data is never dropped. out_data and out_valid stay stable while out_valid && !out_ready.
//  - Latency: start accepted at edge k -> ram_addr=base after k; Rdata after k+1; written to
//    buffer at k+2; out_valid=1 after k+2.
//  - Throughput: 1 word/clock while out_ready=1.
//  - Address step: ram_addr increments per issued read; RAMSIZE-1 wraps to 0. Not a power-of-2
//    wrap.
//  - ram_addr holds its last value when no read issues. Words leave in address-issue order.
//  - busy=1 in RUN and DRAIN.
// CONFIGURATION
//  MEM_CLEAR_ON_READ_EN defined:
//    ram_wenable=1 exactly in cycles where a read issues; ram_wdata=0. The RAM is
//    read-before-write, so the old word is returned and the location is zeroed (consume
//    semantics).
//  MEM_CLEAR_ON_READ_EN undefined:
//    ram_wenable tied 0; RAM contents are never modified.
// TESTING
//  1 RAM[i]=i+i; base=0, nwords=8, out_ready=1 -> out_data 0,2,..,14 on 8 consecutive cycles;
//    first valid 2 cycles after start; done 1 cycle after the 8th transfer.
//  2 base=1920, nwords=8 -> ram_addr 1920..1923,0..3; data RAM[1920..1923],RAM[0..3] in order.
//  3 nwords=16, out_ready toggled 1-cycle on/off and held low 5 cycles -> all 16 words in order,
//    no duplicates or losses; out_data stable while stalled.
//  4 start with nwords=0 -> done next cycle, no ram_addr change, out_valid never set.
//    base=1924 -> err pulse only.
//  5 reset_n low for 1 cycle after 3 of 10 words -> all outputs 0 immediately. A new start
//    (base=5, nwords=2) returns RAM[5],RAM[6].
//  6 MEM_CLEAR_ON_READ_EN, base=10, nwords=4 -> data = original words; RAM[10..13] read 0 on a
//    second pass.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Port master for one port of a dual-port RAM. Reads nwords words starting
//   at base_addr (addresses wrap modulo RAMSIZE) and streams them out in
//   address order on a valid/ready interface. The RAM has a 1-cycle
//   registered read. A 2-entry output buffer plus a one-deep in-flight flag
//   hides that latency and sustains 1 word/clock.
//
//   Optional feature macro: MEM_CLEAR_ON_READ_EN
//     defined   : ram_wenable pulses with every issued read and ram_wdata=0.
//                 This zeroes each consumed word on a read-before-write RAM.
//     undefined : ram_wenable tied 0; RAM contents are never modified.
//
// Ports
//   clock, reset_n           clock / async active-low reset
//   start, base_addr, nwords job request (sampled only in IDLE)
//   busy, done, err          job status (done/err are 1-cycle pulses)
//   ram_addr, ram_wdata,
//   ram_wenable, ram_rdata   RAM port
//   out_data, out_valid,
//   out_ready                output stream
module ram_stream_reader #(
  parameter  int RAMSIZE   = 1924,
  parameter  int DATAWIDTH = 32,
  localparam int AW        = $clog2(RAMSIZE)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [AW:0]          nwords,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [AW-1:0]        ram_addr,
  output logic [DATAWIDTH-1:0] ram_wdata,
  output logic                 ram_wenable,
  input  logic [DATAWIDTH-1:0] ram_rdata,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // AW+1 bits so RAMSIZE itself is representable even for power-of-2 sizes
  localparam logic [AW:0]   RAMSIZE_W = (AW+1)'(RAMSIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAMSIZE-1);

  logic [1:0]                  state_q, state_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [AW:0]                 remain_q, remain_d;  // reads still to issue
  logic                        inflight_q;          // ram_rdata holds a word this cycle
  logic [1:0][DATAWIDTH-1:0]   fifo_q;
  logic                        rd_ptr_q, wr_ptr_q;
  logic [1:0]                  count_q;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic                        pop, issue;
  logic [2:0]                  occ;
  logic [AW:0]                 n_clamped;
  logic [AW-1:0]               addr_inc;

  assign pop = (count_q != 2'd0) && out_ready;

  // Slots already committed once this cycle's pop is accounted for. An issue
  // is allowed only if the word it returns is guaranteed a buffer slot.
  assign occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (remain_q != '0) && (occ < 3'd2);

  assign n_clamped = (nwords > RAMSIZE_W) ? RAMSIZE_W : nwords;
  assign addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ({1'b0, base_addr} >= RAMSIZE_W) begin
            err_d = 1'b1;
          end else if (nwords == '0) begin
            done_d = 1'b1;
          end else begin
            // ram_addr presents base right away; the first read issues in
            // the following cycle
            state_d  = RUN;
            addr_d   = base_addr;
            remain_d = n_clamped;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = addr_inc;
          remain_d = remain_q - 1'b1;
          if (remain_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((count_q == 2'd0) && !inflight_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      fifo_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      inflight_q <= issue;
      done_q     <= done_d;
      err_q      <= err_d;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= ram_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = '0;
  assign out_data  = fifo_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);

`ifdef MEM_CLEAR_ON_READ_EN
  assign ram_wenable = issue;
`else
  assign ram_wenable = 1'b0;
`endif

endmodule
